// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise pipeline: op encodings and the per-bit evaluator.
// Purely combinational helpers; no latency.
// No flow control here; handshakes live in the datapath modules.
package bitwise_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND    = 3'd0;
    localparam logic [OP_W-1:0] OP_OR     = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'd6;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'd7;

    // One bit slice; callers replicate it across the operand width.
    function automatic logic bitwise_eval(input logic a, input logic b,
                                          input logic [OP_W-1:0] op);
        case (op)
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_XOR:    return a ^ b;
            OP_NAND:   return ~(a & b);
            OP_NOR:    return ~(a | b);
            OP_XNOR:   return ~(a ^ b);
            OP_PASS_A: return a;
            OP_NOT_A:  return ~a;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bitwise_fifo2.sv
// Generic two-entry valid/ready buffer.
// Latency: data written on an accepting edge is at the head on the next cycle when empty.
// Backpressure: in_ready is a registered "not full"; out_ready never reaches in_ready combinationally.
module bitwise_fifo2 #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic              ready_q;
    logic              push;
    logic              pop;

    assign out_valid = (count != 2'd0);
    assign in_ready  = ready_q;
    assign push      = in_valid && ready_q;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // ready_q mirrors "not full" one edge ahead, and stays low while held in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            ready_q <= 1'b0;
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            count   <= count_nxt;
            ready_q <= (count_nxt != 2'd2);
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule

// File: rtl/bitwise_unit_pipe.sv
// Registered bitwise unit: eight ops on two WIDTH-bit operands with zero/all-ones flags.
// Latency: result valid the cycle after acceptance into an empty buffer; FIFO order otherwise.
// Backpressure: 2-entry buffer; in_ready drops when full, head held stable while out_ready is low.
module bitwise_unit_pipe
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0] op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WIDTH-1:0] y,
    output logic            y_zero,
    output logic            y_ones,
    output logic [CNT_W-1:0] op_count
);

    localparam int DATA_W = WIDTH + 2;

    logic [WIDTH-1:0]  res;
    logic              res_zero;
    logic              res_ones;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = bitwise_eval(a[i], b[i], op);
        end
    end

    // Flags are captured with the entry so the head never needs re-evaluation.
    assign res_zero = (res == '0);
    assign res_ones = &res;
    assign wr_data  = {res_ones, res_zero, res};

    bitwise_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (rd_data)
    );

    assign {y_ones, y_zero, y} = rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Scoreboard bench for bitwise_unit_pipe (WIDTH=8, CNT_W=4 so the counter wraps quickly).
module tb_bitwise_unit_pipe;
    import bitwise_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       y_zero;
    logic       y_ones;
    logic [3:0] op_count;

    bitwise_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_zero    (y_zero),
        .y_ones    (y_ones),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        bit         lat;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [3:0] exp_cnt  = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the head against the scoreboard every cycle, pops on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("op_count", op_count, exp_cnt);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_out_valid: y=%0h with empty scoreboard", y);
                end else begin
                    check("y", y, sb[0].y);
                    check("y_zero", y_zero, sb[0].y == 8'h00);
                    check("y_ones", y_ones, sb[0].y == 8'hFF);
                    if (out_ready) begin
                        if (sb[0].lat) check("latency", cyc, sb[0].acc + 1);
                        void'(sb.pop_front());
                        exp_cnt = exp_cnt + 4'd1;
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                        input logic [7:0] ey, input bit lat);
        bit done;
        exp_t e;
        done     = 1'b0;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        op       = iop;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.y   = ey;
                e.lat = lat;
                e.acc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: in_ready stayed 0 for op %0d", iop);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        exp_cnt = 4'd0;
    endtask

    logic [7:0] ops_exp  [8]  = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h0F};
    logic [7:0] sim_a    [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF, 8'h00};
    logic [7:0] sim_exp  [10] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'h00, 8'hFF};

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        op        = 3'd0;
        do_reset();
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, 8'h00);
        check("rst_op_count", op_count, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // All eight ops back to back with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'hF0, 8'hCC, 3'(i), ops_exp[i], 1'b1);
        drain();
        check("ops_op_count", op_count, 4'd8);

        // Flag extremes.
        push(8'hFF, 8'h00, OP_AND, 8'h00, 1'b1);
        push(8'hFF, 8'h00, OP_OR,  8'hFF, 1'b1);
        drain();

        // Back-pressure: third set must wait for the consumer.
        out_ready = 1'b0;
        push(8'h12, 8'h34, OP_XOR, 8'h26, 1'b0);
        push(8'h5A, 8'h3C, OP_AND, 8'h18, 1'b0);
        check("full_in_ready", in_ready, 1'b0);
        check("full_out_valid", out_valid, 1'b1);
        fork
            push(8'h01, 8'h02, OP_NOR, 8'hFC, 1'b0);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check("held_in_ready", in_ready, 1'b0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Accept and pop on the same edge with one entry resident.
        out_ready = 1'b0;
        push(8'hAA, 8'h55, OP_AND, 8'h00, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(sim_a[i], 8'h5A, OP_NOT_A, sim_exp[i], 1'b1);
            check("steady_in_ready", in_ready, 1'b1);
            check("steady_out_valid", out_valid, 1'b1);
        end
        drain();

        // Reset while two results are buffered.
        out_ready = 1'b0;
        push(8'hF0, 8'h0F, OP_OR,  8'hFF, 1'b0);
        push(8'h33, 8'h0F, OP_AND, 8'h03, 1'b0);
        #2 do_reset();
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_y", y, 8'h00);
        check("midrst_y_ones", y_ones, 1'b0);
        check("midrst_op_count", op_count, 4'd0);
        check("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_release_in_ready", in_ready, 1'b1);
        check("midrst_release_out_valid", out_valid, 1'b0);

        // Counter wrap at 2^4.
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) push(8'(i * 3), 8'h00, OP_PASS_A, 8'(i * 3), 1'b1);
        drain();
        check("wrap_15", op_count, 4'd15);
        push(8'h7E, 8'h81, OP_XNOR, 8'h00, 1'b1);
        drain();
        check("wrap_16", op_count, 4'd0);
        push(8'h7E, 8'h81, OP_XOR, 8'hFF, 1'b1);
        drain();
        check("wrap_17", op_count, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
